mode_sequencer: RTL and testbench

//   Owns switching between the calculator and puzzle modes, which share the LCD, LEDs, 7-seg and piezo.

---
 rtl/mode_sequencer.sv | 164 ++++++++++++++++
 tb/tb_mode_sequencer.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/mode_sequencer.sv
// Purpose : owns the calculator/puzzle mode switch; debounces the raw switch, holds both modes in reset
//           with shared outputs blanked for a settle window, then releases only the selected mode.
// Latency : mode_sel/resets/out_blank update the cycle after the debounced level toggles; RUN after SETTLE_CYCLES.
// Backpr. : none; free-running control block with no handshake; switch changes are absorbed by restarting SETTLE.
//
// Ports:
//   clk            system clock
//   rst            synchronous active-low reset
//   mode_switch    raw asynchronous switch (0 = calculator, 1 = puzzle)
//   mode_sel       registered; 1 = calculator active, 0 = puzzle active
//   rst_calculator active-high reset to the calculator mode
//   rst_puzzle     active-high reset to the puzzle mode
//   out_blank      1 = top forces LCD/LED/7-seg/piezo inactive
//   busy           1 while not in RUN
//   switch_evt     one-cycle pulse per accepted mode change (never on power-up)
module mode_sequencer #(
   parameter int DEBOUNCE_CYCLES = 20000,
   parameter int SETTLE_CYCLES   = 1000,
   parameter int CNT_W           = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic mode_switch,
   output logic mode_sel,
   output logic rst_calculator,
   output logic rst_puzzle,
   output logic out_blank,
   output logic busy,
   output logic switch_evt
);

   typedef enum logic [1:0] {
      ST_INIT   = 2'd0,
      ST_SETTLE = 2'd1,
      ST_RUN    = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [CNT_W-1:0] SET_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state, state_nxt;
   logic             sw_m, sw_s, sw_prev;
   logic             deb_level, deb_level_nxt;
   logic [CNT_W-1:0] deb_cnt, deb_cnt_nxt;
   logic [CNT_W-1:0] init_cnt, init_cnt_nxt;
   logic [CNT_W-1:0] set_cnt, set_cnt_nxt;
   logic             mode_sel_nxt;
   logic             switch_evt_nxt;
   logic             mode_stale;
   logic             run_nxt;
   logic             rst_calculator_nxt, rst_puzzle_nxt, out_blank_nxt;

   // ---------------------------------------------------------------------
   // Next-state / next-output logic
   // ---------------------------------------------------------------------
   always_comb begin
      state_nxt      = state;
      mode_sel_nxt   = mode_sel;
      switch_evt_nxt = 1'b0;
      deb_level_nxt  = deb_level;
      deb_cnt_nxt    = '0;
      init_cnt_nxt   = '0;
      set_cnt_nxt    = set_cnt;
      // mode_sel is the inverse of the level it was derived from, so equality
      // means the debounced switch no longer agrees with the active mode.
      mode_stale     = (deb_level == mode_sel);

      // Debounce runs only once INIT has latched a trusted level. Any cycle
      // where sw_s agrees with deb_level leaves deb_cnt at its default of 0.
      // The >= compare also bounds the count, so it can never wrap.
      if (state != ST_INIT && sw_s != deb_level) begin
         if (deb_cnt >= DEB_LAST) begin
            deb_level_nxt = ~deb_level;
         end else begin
            deb_cnt_nxt = deb_cnt + 1'b1;
         end
      end

      case (state)
         ST_INIT: begin
            if (sw_s != sw_prev) begin
               init_cnt_nxt = '0;
            end else if (init_cnt >= DEB_LAST) begin
               state_nxt     = ST_SETTLE;
               deb_level_nxt = sw_s;
               mode_sel_nxt  = ~sw_s;
               set_cnt_nxt   = '0;
            end else begin
               init_cnt_nxt = init_cnt + 1'b1;
            end
         end
         ST_SETTLE: begin
            // A toggle beats the terminal count: the window restarts rather
            // than releasing a mode that is about to be switched away from.
            if (mode_stale) begin
               mode_sel_nxt   = ~deb_level;
               switch_evt_nxt = 1'b1;
               set_cnt_nxt    = '0;
            end else if (set_cnt >= SET_LAST) begin
               state_nxt   = ST_RUN;
               set_cnt_nxt = '0;
            end else begin
               set_cnt_nxt = set_cnt + 1'b1;
            end
         end
         ST_RUN: begin
            if (mode_stale) begin
               state_nxt      = ST_SETTLE;
               mode_sel_nxt   = ~deb_level;
               switch_evt_nxt = 1'b1;
               set_cnt_nxt    = '0;
            end
         end
         default: begin
            state_nxt = ST_INIT;
         end
      endcase

      // Outputs derive from the next state so they flip on the same edge as
      // the state register; at most one reset can be released, only in RUN.
      run_nxt            = (state_nxt == ST_RUN);
      rst_calculator_nxt = ~(run_nxt & mode_sel_nxt);
      rst_puzzle_nxt     = ~(run_nxt & ~mode_sel_nxt);
      out_blank_nxt      = ~run_nxt;
   end

   // ---------------------------------------------------------------------
   // State, counters, synchroniser and registered outputs
   // ---------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst) begin
         state          <= ST_INIT;
         sw_m           <= 1'b0;
         sw_s           <= 1'b0;
         sw_prev        <= 1'b0;
         deb_level      <= 1'b0;
         deb_cnt        <= '0;
         init_cnt       <= '0;
         set_cnt        <= '0;
         mode_sel       <= 1'b1;
         rst_calculator <= 1'b1;
         rst_puzzle     <= 1'b1;
         out_blank      <= 1'b1;
         busy           <= 1'b1;
         switch_evt     <= 1'b0;
      end else begin
         state          <= state_nxt;
         sw_m           <= mode_switch;
         sw_s           <= sw_m;
         sw_prev        <= sw_s;
         deb_level      <= deb_level_nxt;
         deb_cnt        <= deb_cnt_nxt;
         init_cnt       <= init_cnt_nxt;
         set_cnt        <= set_cnt_nxt;
         mode_sel       <= mode_sel_nxt;
         rst_calculator <= rst_calculator_nxt;
         rst_puzzle     <= rst_puzzle_nxt;
         out_blank      <= out_blank_nxt;
         busy           <= out_blank_nxt;
         switch_evt     <= switch_evt_nxt;
      end
   end

endmodule

// File: tb/tb_mode_sequencer.sv
// Purpose : directed check of mode_sequencer power-up, switching, glitch rejection, SETTLE restarts and reset abort.
// Latency : every output is compared 1 time unit after each rising edge against hand-derived expectations.
// Backpr. : none; stimulus is a fixed linear sequence, no waits on DUT events.
module tb_mode_sequencer;

   // Output bundle order: {mode_sel, rst_calculator, rst_puzzle, out_blank, busy, switch_evt}
   localparam logic [5:0] BLANK_CALC = 6'b111110;  // INIT / reset / SETTLE toward calculator
   localparam logic [5:0] EVT_CALC   = 6'b111111;  // first SETTLE cycle of a change to calculator
   localparam logic [5:0] BLANK_PUZ  = 6'b011110;  // SETTLE toward puzzle
   localparam logic [5:0] EVT_PUZ    = 6'b011111;  // first SETTLE cycle of a change to puzzle
   localparam logic [5:0] RUN_CALC   = 6'b101000;
   localparam logic [5:0] RUN_PUZ    = 6'b010000;

   logic clk = 1'b0;
   logic rst;
   logic sw_a, sw_b;

   logic a_mode_sel, a_rst_calculator, a_rst_puzzle, a_out_blank, a_busy, a_switch_evt;
   logic b_mode_sel, b_rst_calculator, b_rst_puzzle, b_out_blank, b_busy, b_switch_evt;
   logic [5:0] obs_a, obs_b;

   int vectors     = 0;
   int miscompares = 0;

   always #5 clk = ~clk;

   // Instance a uses the reference parameters. With DEBOUNCE=4 > SETTLE=3 a
   // second debounced toggle can never land inside one settle window, so
   // instance b widens the window to reach the in-SETTLE restart cases.
   mode_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(3), .CNT_W(16)) dut_a (
      .clk            (clk),
      .rst            (rst),
      .mode_switch    (sw_a),
      .mode_sel       (a_mode_sel),
      .rst_calculator (a_rst_calculator),
      .rst_puzzle     (a_rst_puzzle),
      .out_blank      (a_out_blank),
      .busy           (a_busy),
      .switch_evt     (a_switch_evt)
   );

   mode_sequencer #(.DEBOUNCE_CYCLES(4), .SETTLE_CYCLES(6), .CNT_W(16)) dut_b (
      .clk            (clk),
      .rst            (rst),
      .mode_switch    (sw_b),
      .mode_sel       (b_mode_sel),
      .rst_calculator (b_rst_calculator),
      .rst_puzzle     (b_rst_puzzle),
      .out_blank      (b_out_blank),
      .busy           (b_busy),
      .switch_evt     (b_switch_evt)
   );

   assign obs_a = {a_mode_sel, a_rst_calculator, a_rst_puzzle, a_out_blank, a_busy, a_switch_evt};
   assign obs_b = {b_mode_sel, b_rst_calculator, b_rst_puzzle, b_out_blank, b_busy, b_switch_evt};

   // Both mode resets must never be released together, in any cycle.
   always @(negedge clk) begin
      vectors++;
      assert (!(a_rst_calculator === 1'b0 && a_rst_puzzle === 1'b0)) else begin
         miscompares++;
         $error("FAIL overlap_a observed rst_calculator=%b rst_puzzle=%b expected not both 0",
                a_rst_calculator, a_rst_puzzle);
      end
      vectors++;
      assert (!(b_rst_calculator === 1'b0 && b_rst_puzzle === 1'b0)) else begin
         miscompares++;
         $error("FAIL overlap_b observed rst_calculator=%b rst_puzzle=%b expected not both 0",
                b_rst_calculator, b_rst_puzzle);
      end
   end

   task automatic check(input string tag, input logic [5:0] obs, input logic [5:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Advance n cycles, comparing both instances after every rising edge.
   task automatic step(input string tag, input int n, input logic [5:0] exp_a, input logic [5:0] exp_b);
      for (int i = 0; i < n; i++) begin
         @(posedge clk);
         #1;
         check({tag, "/a"}, obs_a, exp_a);
         check({tag, "/b"}, obs_b, exp_b);
      end
   endtask

   initial begin
      rst  = 1'b0;
      sw_a = 1'b0;
      sw_b = 1'b0;

      // 1) Power-up: 4 INIT cycles, then SETTLE (3 for a, 6 for b), then calculator runs.
      step("reset",          2, BLANK_CALC, BLANK_CALC);
      rst = 1'b1;
      step("pwrup_init",     4, BLANK_CALC, BLANK_CALC);
      step("pwrup_settle",   2, BLANK_CALC, BLANK_CALC);
      step("pwrup_run_a",    3, RUN_CALC,   BLANK_CALC);
      step("pwrup_run_b",    1, RUN_CALC,   RUN_CALC);

      // 2) a: switch 0->1 held; 2 sync + 4 debounce edges, then the change edge.
      sw_a = 1'b1;
      step("up_debounce",    6, RUN_CALC,   RUN_CALC);
      step("up_evt",         1, EVT_PUZ,    RUN_CALC);
      step("up_settle",      2, BLANK_PUZ,  RUN_CALC);
      step("up_run",         1, RUN_PUZ,    RUN_CALC);

      // 3) a: 3-cycle glitch reaches deb_cnt=3 but never the toggle.
      sw_a = 1'b0;
      step("glitch",         3, RUN_PUZ,    RUN_CALC);
      sw_a = 1'b1;
      step("glitch_after",   8, RUN_PUZ,    RUN_CALC);

      // 4) b: switch flips back during SETTLE; second event restarts the window.
      sw_b = 1'b1;
      step("back_sync",      4, RUN_PUZ,    RUN_CALC);
      sw_b = 1'b0;
      step("back_debounce",  2, RUN_PUZ,    RUN_CALC);
      step("back_evt1",      1, RUN_PUZ,    EVT_PUZ);
      step("back_settle1",   3, RUN_PUZ,    BLANK_PUZ);
      step("back_evt2",      1, RUN_PUZ,    EVT_CALC);
      step("back_settle2",   5, RUN_PUZ,    BLANK_CALC);
      step("back_run",       4, RUN_PUZ,    RUN_CALC);

      // 6) b: second toggle lands on the SETTLE terminal-count cycle; toggle wins.
      sw_b = 1'b1;
      step("term_debounce",  6, RUN_PUZ,    RUN_CALC);
      sw_b = 1'b0;
      step("term_evt1",      1, RUN_PUZ,    EVT_PUZ);
      step("term_settle1",   5, RUN_PUZ,    BLANK_PUZ);
      step("term_evt2",      1, RUN_PUZ,    EVT_CALC);
      step("term_settle2",   5, RUN_PUZ,    BLANK_CALC);
      step("term_run",       1, RUN_PUZ,    RUN_CALC);

      // 5) b heads for puzzle; reset mid-SETTLE aborts both, mode_sel returns to 1.
      sw_b = 1'b1;
      step("abort_debounce", 6, RUN_PUZ,    RUN_CALC);
      step("abort_evt",      1, RUN_PUZ,    EVT_PUZ);
      step("abort_settle",   1, RUN_PUZ,    BLANK_PUZ);
      rst = 1'b0;
      step("abort_reset",    1, BLANK_CALC, BLANK_CALC);
      rst = 1'b1;
      // Synchroniser restarts at 0 while both switches sit at 1: INIT sees the
      // change two edges in, restarts its count, and exits 7 edges after release.
      step("abort_init",     6, BLANK_CALC, BLANK_CALC);
      step("abort_settle_p", 3, BLANK_PUZ,  BLANK_PUZ);
      step("abort_run_a",    3, RUN_PUZ,    BLANK_PUZ);
      step("abort_run_b",    1, RUN_PUZ,    RUN_PUZ);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
